// File: rtl/mii_pkg.sv
// Shared MII byte-stream definitions: FSM states, error causes
// and the default control codes used by generator and checker.
package mii_pkg;

  typedef enum logic [2:0] {
    HUNT,
    PRE,
    DATA,
    EOFCHK,
    RESYNC
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_PRE_SHORT = 3'd1,
    ERR_PRE_LONG  = 3'd2,
    ERR_PRE_BAD   = 3'd3,
    ERR_EOF_BAD   = 3'd4
  } err_code_t;

  localparam int         PREAMBLE_CYCLES_DEF = 7;
  localparam int         DATA_CYCLES_DEF     = 46;
  localparam logic [7:0] IDLE_CODE_DEF       = 8'h00;
  localparam logic [7:0] PREAMBLE_CODE_DEF   = 8'h55;
  localparam logic [7:0] SFD_CODE_DEF        = 8'hD5;
  localparam logic [7:0] EOF_CODE_DEF        = 8'h00;

endpackage

// File: rtl/mii_frame_checker_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mii_frame_checker.sv
// Receive-side MII deframer: preamble/SFD hunt, payload
// extraction, EOF check, error reporting and frame counters.
module mii_frame_checker
  import mii_pkg::*;
#(
  parameter int         PREAMBLE_CYCLES = PREAMBLE_CYCLES_DEF,
  parameter int         DATA_CYCLES     = DATA_CYCLES_DEF,
  parameter logic [7:0] IDLE_CODE       = IDLE_CODE_DEF,
  parameter logic [7:0] PREAMBLE_CODE   = PREAMBLE_CODE_DEF,
  parameter logic [7:0] SFD_CODE        = SFD_CODE_DEF,
  parameter logic [7:0] EOF_CODE        = EOF_CODE_DEF
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_rx_data,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic [7:0]  o_data_idx,
  output logic        o_frame_done,
  output logic        o_frame_err,
  output logic [2:0]  o_err_code,
  output logic [7:0]  o_frame_xor,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt
);

  localparam logic [3:0] PRE_N = 4'(PREAMBLE_CYCLES);
  localparam logic [7:0] LAST  = 8'(DATA_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  pre_q, pre_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  xor_q, xor_d;
  err_code_t   code_q, code_d;
  logic [7:0]  data_d, didx_d, fxor_d;
  logic        dv_d, done_d, err_d;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    code_d  = code_q;
    data_d  = o_data;
    didx_d  = o_data_idx;
    fxor_d  = o_frame_xor;
    dv_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (i_valid) begin
      unique case (state_q)
        HUNT: begin
          if (i_rx_data == PREAMBLE_CODE) begin
            state_d = PRE;
            pre_d   = 4'd1;
          end
        end
        PRE: begin
          unique case (1'b1)
            (i_rx_data == PREAMBLE_CODE): begin
              if (pre_q == PRE_N) begin
                err_d  = 1'b1;
                code_d = ERR_PRE_LONG;
              end else begin
                pre_d = pre_q + 4'd1;
              end
            end
            (i_rx_data == SFD_CODE): begin
              if (pre_q == PRE_N) begin
                state_d = DATA;
                idx_d   = 8'd0;
                xor_d   = 8'd0;
              end else begin
                err_d  = 1'b1;
                code_d = ERR_PRE_SHORT;
              end
            end
            default: begin
              err_d  = 1'b1;
              code_d = ERR_PRE_BAD;
            end
          endcase
        end
        DATA: begin
          dv_d   = 1'b1;
          data_d = i_rx_data;
          didx_d = idx_q;
          xor_d  = xor_q ^ i_rx_data;
          if (idx_q == LAST) begin
            state_d = EOFCHK;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        EOFCHK: begin
          if (i_rx_data == EOF_CODE) begin
            done_d  = 1'b1;
            fxor_d  = xor_q;
            state_d = HUNT;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_EOF_BAD;
          end
        end
        RESYNC: begin
          if (i_rx_data == IDLE_CODE) begin
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
      // Any error drops into RESYNC so payload 0x55 cannot restart a frame
      if (err_d) begin
        state_d = RESYNC;
      end
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= HUNT;
      pre_q        <= 4'd0;
      idx_q        <= 8'd0;
      xor_q        <= 8'd0;
      code_q       <= ERR_NONE;
      o_data       <= 8'd0;
      o_data_valid <= 1'b0;
      o_data_idx   <= 8'd0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      o_frame_xor  <= 8'd0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      xor_q        <= xor_d;
      code_q       <= code_d;
      o_data       <= data_d;
      o_data_valid <= dv_d;
      o_data_idx   <= didx_d;
      o_frame_done <= done_d;
      o_frame_err  <= err_d;
      o_frame_xor  <= fxor_d;
    end
  end

  assign o_err_code = code_q;

  sat_counter #(.WIDTH(16)) u_frame_cnt (
    .clk   (clk),
    .i_rst (i_rst),
    .inc   (done_d),
    .count (o_frame_cnt)
  );

  sat_counter #(.WIDTH(16)) u_err_cnt (
    .clk   (clk),
    .i_rst (i_rst),
    .inc   (err_d),
    .count (o_err_cnt)
  );

endmodule

// File: tb/tb_mii_frame_checker.sv
// Directed bench for mii_frame_checker: vector table for the
// preamble error paths plus hand-written frame sequences.
module tb_mii_frame_checker;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [7:0]  i_rx_data;
  logic [7:0]  o_data;
  logic        o_data_valid;
  logic [7:0]  o_data_idx;
  logic        o_frame_done;
  logic        o_frame_err;
  logic [2:0]  o_err_code;
  logic [7:0]  o_frame_xor;
  logic [15:0] o_frame_cnt;
  logic [15:0] o_err_cnt;

  int total = 0;
  int bad   = 0;

  mii_frame_checker dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_rx_data    (i_rx_data),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_data_idx   (o_data_idx),
    .o_frame_done (o_frame_done),
    .o_frame_err  (o_frame_err),
    .o_err_code   (o_err_code),
    .o_frame_xor  (o_frame_xor),
    .o_frame_cnt  (o_frame_cnt),
    .o_err_cnt    (o_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        err;
    logic [2:0]  code;
    logic [15:0] ecnt;
    string       name;
  } vec_t;

  vec_t vq[$];

  task automatic push(input logic v, input logic [7:0] d,
                      input logic err, input logic [2:0] code,
                      input logic [15:0] ecnt, input string name);
    vec_t r;
    r.v = v; r.d = d; r.err = err;
    r.code = code; r.ecnt = ecnt; r.name = name;
    vq.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    i_valid   = v;
    i_rx_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string nm);
    chk({nm, "_dv"}, o_data_valid, 0);
    chk({nm, "_done"}, o_frame_done, 0);
    chk({nm, "_err"}, o_frame_err, 0);
  endtask

  function automatic logic [7:0] pay(input bit mix, input int i);
    logic [7:0] m [3];
    m[0] = 8'h55; m[1] = 8'hD5; m[2] = 8'h00;
    return mix ? m[i % 3] : 8'(i);
  endfunction

  task automatic send_frame(input int n_idle, input bit gap,
                            input bit mix, input bit good,
                            input logic [15:0] fcnt,
                            input logic [15:0] ecnt,
                            input logic [7:0] xr);
    int cyc = 0;
    for (int i = 0; i < n_idle; i++) begin
      step(1'b1, 8'h00);
      quiet("idle");
    end
    for (int i = 0; i < 7 + 1 + 46 + 1; i++) begin
      logic [7:0] b;
      cyc++;
      if (gap && (cyc % 3 == 0)) begin
        step(1'b0, 8'h07);
        quiet("gap");
      end
      if (i < 7) b = 8'h55;
      else if (i == 7) b = 8'hD5;
      else if (i < 54) b = pay(mix, i - 8);
      else b = good ? 8'h00 : 8'h07;
      step(1'b1, b);
      if (i < 8) begin
        quiet("pre");
      end else if (i < 54) begin
        chk("pay_dv", o_data_valid, 1);
        chk("pay_data", o_data, b);
        chk("pay_idx", o_data_idx, i - 8);
        chk("pay_err", o_frame_err, 0);
      end else if (good) begin
        chk("eof_done", o_frame_done, 1);
        chk("eof_err", o_frame_err, 0);
        chk("eof_xor", o_frame_xor, xr);
        chk("eof_fcnt", o_frame_cnt, fcnt);
        chk("eof_ecnt", o_err_cnt, ecnt);
      end else begin
        chk("beof_err", o_frame_err, 1);
        chk("beof_done", o_frame_done, 0);
        chk("beof_code", o_err_code, 4);
        chk("beof_fcnt", o_frame_cnt, fcnt);
        chk("beof_ecnt", o_err_cnt, ecnt);
      end
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_rx_data = 8'h00;
    #1;
    chk("rst_data", o_data, 0);
    chk("rst_dv", o_data_valid, 0);
    chk("rst_idx", o_data_idx, 0);
    chk("rst_done", o_frame_done, 0);
    chk("rst_err", o_frame_err, 0);
    chk("rst_code", o_err_code, 0);
    chk("rst_xor", o_frame_xor, 0);
    chk("rst_fcnt", o_frame_cnt, 0);
    chk("rst_ecnt", o_err_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;

    push(1, 8'h00, 0, 0, 0, "hunt_idle");
    push(1, 8'hD5, 0, 0, 0, "hunt_ign");
    for (int i = 0; i < 6; i++) push(1, 8'h55, 0, 0, 0, "spre");
    push(1, 8'hD5, 1, 1, 1, "short_sfd");
    push(1, 8'h55, 0, 1, 1, "rs_ign55");
    push(1, 8'h00, 0, 1, 1, "rs_idle");
    for (int i = 0; i < 7; i++) push(1, 8'h55, 0, 1, 1, "lpre");
    push(1, 8'h55, 1, 2, 2, "long_8th");
    push(1, 8'h55, 0, 2, 2, "rs_ign55b");
    push(1, 8'hD5, 0, 2, 2, "rs_ignsfd");
    push(0, 8'h00, 0, 2, 2, "rs_inv_idle");
    push(1, 8'h55, 0, 2, 2, "rs_still");
    push(1, 8'h07, 0, 2, 2, "rs_still07");
    push(1, 8'h00, 0, 2, 2, "rs_idle2");
    push(1, 8'h55, 0, 2, 2, "bad_pre1");
    push(0, 8'h07, 0, 2, 2, "bad_inv");
    push(1, 8'h07, 1, 3, 3, "pre_bad");
    push(1, 8'h00, 0, 3, 3, "rs_idle3");

    for (int k = 0; k < vq.size(); k++) begin
      step(vq[k].v, vq[k].d);
      chk({vq[k].name, "_err"}, o_frame_err, vq[k].err);
      chk({vq[k].name, "_code"}, o_err_code, vq[k].code);
      chk({vq[k].name, "_ecnt"}, o_err_cnt, vq[k].ecnt);
      chk({vq[k].name, "_done"}, o_frame_done, 0);
      chk({vq[k].name, "_dv"}, o_data_valid, 0);
      chk({vq[k].name, "_fcnt"}, o_frame_cnt, 0);
    end

    send_frame(3, 0, 0, 1, 16'd1, 16'd3, 8'h01);
    send_frame(0, 0, 0, 0, 16'd1, 16'd4, 8'h01);
    step(1'b1, 8'h00);
    quiet("post_beof");
    send_frame(0, 1, 0, 1, 16'd2, 16'd4, 8'h01);
    send_frame(0, 0, 1, 1, 16'd3, 16'd4, 8'hD5);

    for (int i = 0; i < 7; i++) step(1'b1, 8'h55);
    step(1'b1, 8'hD5);
    for (int i = 0; i <= 20; i++) step(1'b1, 8'(i));
    chk("mid_idx", o_data_idx, 20);
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_data", o_data, 0);
    chk("arst_dv", o_data_valid, 0);
    chk("arst_idx", o_data_idx, 0);
    chk("arst_err", o_frame_err, 0);
    chk("arst_code", o_err_code, 0);
    chk("arst_xor", o_frame_xor, 0);
    chk("arst_fcnt", o_frame_cnt, 0);
    chk("arst_ecnt", o_err_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    step(1'b1, 8'd21);
    quiet("after_rst");
    chk("after_rst_ecnt", o_err_cnt, 0);
    send_frame(1, 0, 0, 1, 16'd1, 16'd0, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
